// File: rtl/polyt0_pkg.sv
// Shared constants and FSM state type for the t0 polynomial unpacker.
package polyt0_pkg;

  localparam int unsigned N        = 256;
  localparam int unsigned D        = 13;
  localparam int unsigned T0_BYTES = N * D / 8;
  localparam int unsigned T0_BIAS  = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

endpackage

// File: rtl/polyt0_unpack_stream.sv
// Streams packed 13-bit t0 coefficients in byte order and emits biased signed coefficients.
// Optional macro POLYT0_UNPACK_IDX_EN adds a coef_idx output tagging each coefficient.
module polyt0_unpack_stream #(
  parameter int unsigned N = polyt0_pkg::N,
  parameter int unsigned D = polyt0_pkg::D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_coef,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
`ifdef POLYT0_UNPACK_IDX_EN
  output logic [7:0]  coef_idx,
`endif
  output logic        done
);

  import polyt0_pkg::state_e;
  import polyt0_pkg::StIdle;
  import polyt0_pkg::StRun;
  import polyt0_pkg::StFin;

  localparam int unsigned NBytes = N * D / 8;
  localparam int unsigned AccW   = D + 7;
  localparam int unsigned CntW   = $clog2(AccW + 1);
  localparam int unsigned BytesW = $clog2(NBytes + 1);
  localparam int unsigned CoefW  = $clog2(N + 1);
  localparam int unsigned Bias   = polyt0_pkg::T0_BIAS;

  state_e              state_q, state_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BytesW-1:0]   nbytes_q, nbytes_d;
  logic [CoefW-1:0]    ncoef_q, ncoef_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      nbytes_q <= '0;
      ncoef_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nbytes_q <= nbytes_d;
      ncoef_q  <= ncoef_d;
    end
  end

  // A byte fits only while cnt <= D-1 and a coefficient needs cnt >= D, so the two
  // handshakes can never fire in the same cycle.
  assign in_ready  = (state_q == StRun) && (cnt_q <= CntW'(D - 1)) &&
                     (nbytes_q < BytesW'(NBytes));
  assign out_valid = (state_q == StRun) && (cnt_q >= CntW'(D));
  assign out_coef  = out_valid ? (32'(Bias) - 32'(acc_q[D-1:0])) : '0;
  assign busy      = (state_q == StRun) || (state_q == StFin);
  assign done      = (state_q == StFin);

`ifdef POLYT0_UNPACK_IDX_EN
  assign coef_idx  = out_valid ? ncoef_q[7:0] : '0;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nbytes_d = nbytes_q;
    ncoef_d  = ncoef_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          acc_d    = '0;
          cnt_d    = '0;
          nbytes_d = '0;
          ncoef_d  = '0;
        end
      end
      StRun: begin
        if (in_valid && in_ready) begin
          // Bits at and above cnt are always zero, so OR-ing places the byte at acc[cnt+7:cnt].
          acc_d    = acc_q | (AccW'(in_byte) << cnt_q);
          cnt_d    = cnt_q + CntW'(8);
          nbytes_d = nbytes_q + BytesW'(1);
        end else if (out_valid && out_ready) begin
          acc_d   = acc_q >> D;
          cnt_d   = cnt_q - CntW'(D);
          ncoef_d = ncoef_q + CoefW'(1);
          if (ncoef_q == CoefW'(N - 1)) state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_polyt0_unpack_stream.sv
// Randomized bench for polyt0_unpack_stream against a bit-level pack model.
module tb_polyt0_unpack_stream;

  localparam int NC = 256;
  localparam int NB = 416;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_coef;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef POLYT0_UNPACK_IDX_EN
  logic [7:0]  coef_idx;
`endif

  always #5 clk = ~clk;

  polyt0_unpack_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_coef  (out_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef POLYT0_UNPACK_IDX_EN
    .coef_idx  (coef_idx),
`endif
    .done      (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] bytes_q [NB];
  int         exp_c   [NC];
  int         got_c   [$];
  int         bi, done_cnt, hold_viol, excl_viol, idx_viol, seq_viol;

  // Reference packing: coefficient i occupies stream bits 13*i .. 13*i+12 of (4096 - c).
  function automatic void pack_model();
    int t;
    int pos;
    for (int i = 0; i < NB; i++) bytes_q[i] = 8'h00;
    for (int i = 0; i < NC; i++) begin
      t = 4096 - exp_c[i];
      for (int b = 0; b < 13; b++) begin
        pos = i * 13 + b;
        bytes_q[pos / 8][pos % 8] = t[b];
      end
    end
  endfunction

  function automatic void random_coefs();
    for (int i = 0; i < NC; i++) exp_c[i] = int'($urandom_range(8191)) - 4095;
    exp_c[0]  = -4095;
    exp_c[1]  = 4096;
    exp_c[NC-1] = 4096;
  endfunction

  task automatic clear_stats();
    got_c.delete();
    bi = 0; done_cnt = 0; hold_viol = 0; excl_viol = 0; idx_viol = 0; seq_viol = 0;
  endtask

  task automatic run_stream(input int gap_pct, input int stall_pct, input int noise_pct,
                            input int stop_bytes, input bit do_start);
    int          post;
    logic        prev_stall;
    logic [31:0] prev_coef;
    post = 0; prev_stall = 1'b0; prev_coef = '0;
    if (do_start) begin
      @(posedge clk); #1 start = 1'b1;
    end
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      start     = (noise_pct > 0) && (bi > 0) && (bi < NB) && ($urandom_range(99) < noise_pct);
      in_valid  = (bi < stop_bytes) && ($urandom_range(99) >= gap_pct);
      in_byte   = in_valid ? bytes_q[bi] : 8'($urandom);
      out_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (prev_stall && (!out_valid || out_coef !== prev_coef)) hold_viol++;
      prev_stall = out_valid && !out_ready;
      prev_coef  = out_coef;
      if (in_ready && out_valid) excl_viol++;
`ifdef POLYT0_UNPACK_IDX_EN
      if (out_valid ? (coef_idx !== 8'(got_c.size())) : (coef_idx !== 8'h00)) idx_viol++;
`endif
      if (done && got_c.size() != NC) seq_viol++;
      if (in_valid && in_ready) bi++;
      if (out_valid && out_ready) got_c.push_back(int'($signed(out_coef)));
      if (done) done_cnt++;
      if (done_cnt > 0 || (stop_bytes < NB && bi >= stop_bytes)) begin
        post++;
        if (post > 3) break;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000 || out_coef !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/vld/busy/done=%b coef=%h, want 0000 coef=0",
               {in_ready, out_valid, busy, done}, out_coef);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 0000", {in_ready, out_valid, busy, done});
    end
  endtask

  task automatic check_poly(input string name);
    n_cmp++;
    if (got_c.size() != NC) begin
      n_fail++;
      $display("FAIL %s_count: got %0d coefficients want %0d", name, got_c.size(), NC);
    end
    for (int i = 0; i < NC && i < got_c.size(); i++) begin
      n_cmp++;
      if (got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL %s_coef[%0d]: got %0d want %0d", name, i, got_c[i], exp_c[i]);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || seq_viol != 0) begin
      n_fail++;
      $display("FAIL %s_done: got %0d pulses (%0d early) want 1 (0 early)", name, done_cnt, seq_viol);
    end
    n_cmp++;
    if (hold_viol != 0 || excl_viol != 0) begin
      n_fail++;
      $display("FAIL %s_handshake: got hold=%0d excl=%0d violations want 0", name, hold_viol, excl_viol);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_end: got %b want 0", name, busy);
    end
  endtask

  task automatic test_zeros();
    for (int i = 0; i < NC; i++) exp_c[i] = 4096;
    pack_model();
    clear_stats();
    run_stream(0, 0, 0, NB, 1'b1);
    check_poly("zeros");
    n_cmp++;
    if (bytes_q[5] !== 8'h00) begin
      n_fail++;
      $display("FAIL zeros_model: got byte %h want 00", bytes_q[5]);
    end
  endtask

  task automatic test_ones();
    for (int i = 0; i < NC; i++) exp_c[i] = -4095;
    pack_model();
    clear_stats();
    run_stream(0, 0, 0, NB, 1'b1);
    check_poly("ones");
    n_cmp++;
    if (got_c.size() > 0 && got_c[0] != int'(32'hFFFFF001)) begin
      n_fail++;
      $display("FAIL ones_encoding: got %h want fffff001", got_c[0]);
    end
  endtask

  task automatic test_roundtrip();
    for (int r = 0; r < 2; r++) begin
      random_coefs();
      pack_model();
      clear_stats();
      run_stream(30, 30, 0, NB, 1'b1);
      check_poly("roundtrip");
    end
  endtask

  task automatic test_start_in_run();
    random_coefs();
    pack_model();
    clear_stats();
    run_stream(20, 20, 10, NB, 1'b1);
    check_poly("start_in_run");
`ifdef POLYT0_UNPACK_IDX_EN
    n_cmp++;
    if (idx_viol != 0) begin
      n_fail++;
      $display("FAIL coef_idx: got %0d mismatching cycles want 0", idx_viol);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit          seen;
    bit          hold_ok;
    random_coefs();
    pack_model();
    clear_stats();
    seen = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b1; in_byte = bytes_q[0]; out_ready = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (in_valid && in_ready) bi++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1 in_byte = bytes_q[bi];
    end
    n_cmp++;
    if (!seen || bi != 2) begin
      n_fail++;
      $display("FAIL first_valid_latency: got seen=%0d after %0d bytes want 1 after 2", seen, bi);
    end
    held = out_coef;
    n_cmp++;
    if (held != 32'(exp_c[0])) begin
      n_fail++;
      $display("FAIL first_coef: got %h want %h", held, 32'(exp_c[0]));
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 in_byte = bytes_q[bi];
      @(negedge clk);
      hold_ok = out_valid && (out_coef === held) && !in_ready;
      if (in_valid && in_ready) bi++;
      n_cmp++;
      if (!hold_ok) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got vld=%b coef=%h rdy=%b want 1 %h 0",
                 k, out_valid, out_coef, in_ready, held);
      end
    end
    run_stream(10, 20, 0, NB, 1'b0);
    check_poly("backpressure");
    n_cmp++;
    if (bi != NB) begin
      n_fail++;
      $display("FAIL backpressure_bytes: got %0d bytes accepted want %0d", bi, NB);
    end
  endtask

  task automatic test_midreset();
    random_coefs();
    pack_model();
    clear_stats();
    run_stream(0, 0, 0, 100, 1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000 || out_coef !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy/vld/busy/done=%b coef=%h want 0000 0",
               {in_ready, out_valid, busy, done}, out_coef);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 0 || bi != 100) begin
      n_fail++;
      $display("FAIL midreset_abandon: got %0d done pulses %0d bytes want 0 and 100", done_cnt, bi);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    random_coefs();
    pack_model();
    clear_stats();
    run_stream(15, 15, 0, NB, 1'b1);
    check_poly("after_reset");
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_roundtrip();
    test_start_in_run();
    test_backpressure();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
